freq_meter: RTL and testbench

- Gated frequency counter that consumes the divided clock outputs of the board clock tree (10 MHz, 1 MHz, 100 kHz taps) or any external pin.
- Counts rising edges of an asynchronous input over a fixed gate window of CLK cycles, then latches the result.
- The latched count feeds the 7-segment display driver and the LEDs for on-board verification of the divider chain.
- Runs entirely in the CLK domain; the measured signal is only sampled, never used as a clock.

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/freq_meter_if.sv | 29 ++
 rtl/freq_meter_bcd_conv.sv | 70 +++++++
 rtl/freq_meter.sv | 118 +++++++++++
 tb/tb_freq_meter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_meter_pkg                                                       |
// | Shared defaults and constants for the gated frequency meter.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package freq_meter_pkg;

    localparam int              c_def_gate_cycles = 100_000_000;
    localparam int              c_def_cnt_w       = 32;
    localparam int              c_bcd_digits      = 8;
    localparam logic [31:0]     c_bcd_sat         = 32'h9999_9999;
    localparam longint unsigned c_bcd_max_bin     = 64'd99_999_999;

    typedef enum logic [0:0] {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/freq_meter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_meter_if                                                        |
// | Measured signal, enable and result bus of the frequency meter.       |
// | BCD signals exist only when FREQ_METER_BCD_EN is defined.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface freq_meter_if
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = c_def_cnt_w
);
    logic             sig;
    logic             en;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             ovf;
`ifdef FREQ_METER_BCD_EN
    logic [31:0]      bcd;
    logic             bcd_valid;

    modport master (output sig, en, input count, valid, ovf, bcd, bcd_valid);
    modport slave  (input sig, en, output count, valid, ovf, bcd, bcd_valid);
`else
    modport master (output sig, en, input count, valid, ovf);
    modport slave  (input sig, en, output count, valid, ovf);
`endif
endinterface
`default_nettype wire

// File: rtl/freq_meter_bcd_conv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_bcd_conv                                                        |
// | Sequential double-dabble: one bit per cycle, done CNT_W+1 cycles     |
// | after start. Built only when FREQ_METER_BCD_EN is defined.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`ifdef FREQ_METER_BCD_EN
module freq_bcd_conv
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = c_def_cnt_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] bin,
    output logic [31:0]      bcd,
    output logic             done
);
    localparam int c_bit_w = $clog2(CNT_W) + 1;

    conv_state_t        r_state;
    logic [CNT_W-1:0]   r_shift;
    logic [31:0]        r_acc;
    logic [c_bit_w-1:0] r_bit;
    logic [31:0]        w_adj;
    logic [31:0]        w_next;

    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < c_bcd_digits; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
        w_next = (w_adj << 1) | 32'(r_shift[CNT_W-1]);
    end

    // A new start always wins, so a conversion in flight is abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CONV_IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_bit   <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_state <= CONV_SHIFT;
                r_shift <= bin;
                r_acc   <= '0;
                r_bit   <= '0;
            end else if (r_state == CONV_SHIFT) begin
                r_acc   <= w_next;
                r_shift <= r_shift << 1;
                r_bit   <= r_bit + c_bit_w'(1);
                if (r_bit == c_bit_w'(CNT_W - 1)) begin
                    r_state <= CONV_IDLE;
                    bcd     <= w_next;
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule
`endif
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_meter                                                           |
// | Counts synchronized rising edges of sig over a GATE_CYCLES window.   |
// | Optional BCD output enabled by FREQ_METER_BCD_EN.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = c_def_gate_cycles,
    parameter int CNT_W       = c_def_cnt_w
) (
    input  logic        clk,
    input  logic        reset,
    freq_meter_if.slave bus
);
    localparam int               c_gate_w  = $clog2(GATE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic                r_sync1, r_sync2, r_sync3;
    logic [c_gate_w-1:0] r_gate;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_sticky;
    logic [CNT_W-1:0]    r_count;
    logic                r_valid;
    logic                r_ovf;
    logic                w_edge_det;
    logic                w_terminal;
    logic                w_at_max;

    assign w_edge_det = r_sync2 & ~r_sync3;
    assign w_terminal = bus.en && (r_gate == c_gate_w'(GATE_CYCLES - 1));
    assign w_at_max   = w_edge_det && (r_edge_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_gate     <= '0;
            r_edge_cnt <= '0;
            r_sticky   <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_sync1 <= bus.sig;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_valid <= 1'b0;
            if (!bus.en) begin
                r_gate     <= '0;
                r_edge_cnt <= '0;
                r_sticky   <= 1'b0;
            end else if (w_terminal) begin
                // An edge seen on the terminal cycle still belongs to this window.
                r_count    <= w_at_max ? c_cnt_max : r_edge_cnt + CNT_W'(w_edge_det);
                r_ovf      <= r_sticky | w_at_max;
                r_valid    <= 1'b1;
                r_gate     <= '0;
                r_edge_cnt <= '0;
                r_sticky   <= 1'b0;
            end else begin
                r_gate <= r_gate + c_gate_w'(1);
                if (w_at_max) begin
                    r_sticky <= 1'b1;
                end else if (w_edge_det) begin
                    r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.valid = r_valid;
    assign bus.ovf   = r_ovf;

`ifdef FREQ_METER_BCD_EN
    logic [31:0] w_conv_bcd;
    logic        w_conv_done;
    logic        w_over;
    logic        r_sat_pend;
    logic        r_sat;

    // Out-of-range results bypass the converter value and show all nines.
    assign w_over = r_ovf || (64'(r_count) > c_bcd_max_bin);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_pend <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            if (r_valid) begin
                r_sat_pend <= w_over;
            end
            if (w_conv_done) begin
                r_sat <= r_sat_pend;
            end
        end
    end

    freq_bcd_conv #(
        .CNT_W (CNT_W)
    ) u_bcd_conv (
        .clk   (clk),
        .reset (reset),
        .start (r_valid),
        .bin   (r_count),
        .bcd   (w_conv_bcd),
        .done  (w_conv_done)
    );

    assign bus.bcd       = r_sat ? c_bcd_sat : w_conv_bcd;
    assign bus.bcd_valid = w_conv_done;
`endif
endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_freq_meter                                                        |
// | Two meters (32-bit and 4-bit counters, 100-cycle gate) against a     |
// | window-level reference model. Revision: 1.0                          |
// +----------------------------------------------------------------------+
module tb_freq_meter;
    localparam int G  = 100;
    localparam int W0 = 32;
    localparam int W1 = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sig   = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    freq_meter_if #(.CNT_W(W0)) if_main ();
    freq_meter_if #(.CNT_W(W1)) if_small ();

    assign if_main.sig  = sig;
    assign if_main.en   = en;
    assign if_small.sig = sig;
    assign if_small.en  = en;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W0)) u_main (
        .clk (clk), .reset (reset), .bus (if_main.slave));
    freq_meter #(.GATE_CYCLES(G), .CNT_W(W1)) u_small (
        .clk (clk), .reset (reset), .bus (if_small.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: raw edge tally per window, saturation applied at close.
    bit [2:0]    hist;
    int          pos;
    longint      raw;
    bit          m_valid;
    longint      m_count [2];
    bit          m_ovf [2];
    int          pend [2];
    logic [31:0] bcd_val [2];
    logic [31:0] m_bcd [2];
    bit          m_bcd_valid [2];

    int half;
    int ph;
    bit rnd;

    function automatic int wd(int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic longint lim(int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic logic [31:0] to_bcd(longint v, bit ovf);
        logic [31:0] r;
        longint      x;
        r = '0;
        x = v;
        if (ovf || x > 99999999) return 32'h9999_9999;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_step();
        bit det;
        if (reset) begin
            hist = '0; pos = 0; raw = 0; m_valid = 0;
            for (int i = 0; i < 2; i++) begin
                m_count[i] = 0; m_ovf[i] = 0; pend[i] = 0;
                bcd_val[i] = '0; m_bcd[i] = '0; m_bcd_valid[i] = 0;
            end
        end else begin
            det = hist[1] & ~hist[2];
            m_valid = 0;
            for (int i = 0; i < 2; i++) begin
                m_bcd_valid[i] = 0;
                if (pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) begin
                        m_bcd[i] = bcd_val[i];
                        m_bcd_valid[i] = 1;
                    end
                end
            end
            if (!en) begin
                pos = 0; raw = 0;
            end else begin
                raw += longint'(det);
                if (pos == G - 1) begin
                    m_valid = 1;
                    for (int i = 0; i < 2; i++) begin
                        m_ovf[i]   = raw > lim(wd(i));
                        m_count[i] = m_ovf[i] ? lim(wd(i)) : raw;
                        bcd_val[i] = to_bcd(m_count[i], m_ovf[i]);
                        pend[i]    = wd(i) + 1;
                    end
                    raw = 0; pos = 0;
                end else begin
                    pos++;
                end
            end
            hist = {hist[1:0], sig};
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid_main", 64'(if_main.valid), 64'(m_valid));
        chk("count_main", 64'(if_main.count), 64'(m_count[0]));
        chk("ovf_main",   64'(if_main.ovf),   64'(m_ovf[0]));
        chk("valid_small", 64'(if_small.valid), 64'(m_valid));
        chk("count_small", 64'(if_small.count), 64'(m_count[1]));
        chk("ovf_small",   64'(if_small.ovf),   64'(m_ovf[1]));
`ifdef FREQ_METER_BCD_EN
        chk("bcd_main",        64'(if_main.bcd),        64'(m_bcd[0]));
        chk("bcd_valid_main",  64'(if_main.bcd_valid),  64'(m_bcd_valid[0]));
        chk("bcd_small",       64'(if_small.bcd),       64'(m_bcd[1]));
        chk("bcd_valid_small", 64'(if_small.bcd_valid), 64'(m_bcd_valid[1]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic next_sig();
        if (rnd) begin
            sig = 1'($urandom_range(0, 1));
        end else if (half > 0) begin
            ph++;
            if (ph >= half) begin
                ph  = 0;
                sig = ~sig;
            end
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            tick();
            next_sig();
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            next_sig();
            cyc++;
        end while (if_main.valid !== 1'b1 && cyc < 400);
        chk("valid_seen", 64'(if_main.valid), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     cyc;
        int     nv;
        longint saved;
        half = 0; ph = 0; rnd = 0;

        // Reset state
        reset = 1'b1; en = 1'b0; sig = 1'b0;
        run(3);
        chk("reset_count", 64'(if_main.count), 64'd0);
        chk("reset_ovf",   64'(if_main.ovf),   64'd0);
        chk("reset_valid", 64'(if_main.valid), 64'd0);

        // CLK/10 input
        reset = 1'b0; en = 1'b1; half = 5; ph = 0;
        wait_valid(cyc);
        chk("first_valid_latency", 64'(cyc), 64'd100);
        wait_valid(cyc);
        chk("window_period", 64'(cyc), 64'd100);
        chk("clk10_count", 64'(if_main.count), 64'd10);
        chk("clk10_ovf",   64'(if_main.ovf),   64'd0);
`ifdef FREQ_METER_BCD_EN
        run(W0 + 1);
        chk("bcd_valid_10", 64'(if_main.bcd_valid), 64'd1);
        chk("bcd_10",       64'(if_main.bcd),       64'h10);
`endif

        // Constant input, low then high
        half = 0; sig = 1'b0;
        wait_valid(cyc);
        wait_valid(cyc);
        chk("const0_period", 64'(cyc), 64'd100);
        chk("const0_count",  64'(if_main.count), 64'd0);
        sig = 1'b1;
        wait_valid(cyc);
        wait_valid(cyc);
        chk("const1_count",  64'(if_main.count), 64'd0);

        // Period-4 input saturates the 4-bit meter
        sig = 1'b0; half = 2; ph = 0;
        wait_valid(cyc);
        wait_valid(cyc);
        chk("p4_count_main",  64'(if_main.count),  64'd25);
        chk("p4_ovf_main",    64'(if_main.ovf),    64'd0);
        chk("p4_count_small", 64'(if_small.count), 64'd15);
        chk("p4_ovf_small",   64'(if_small.ovf),   64'd1);
`ifdef FREQ_METER_BCD_EN
        run(W1 + 1);
        chk("bcd_sat_small", 64'(if_small.bcd), 64'h9999_9999);
`endif
        half = 0; sig = 1'b0;
        wait_valid(cyc);
        wait_valid(cyc);
        chk("p4_recover_count", 64'(if_small.count), 64'd0);
        chk("p4_recover_ovf",   64'(if_small.ovf),   64'd0);

        // Single edge detected exactly on the terminal cycle
        for (int i = 0; i < 200 && pos != G - 3; i++) run(1);
        sig = 1'b1;
        wait_valid(cyc);
        chk("term_edge_count", 64'(if_main.count), 64'd1);
        wait_valid(cyc);
        chk("term_next_count", 64'(if_main.count), 64'd0);

        // Reset in mid-window
        sig = 1'b0; half = 5; ph = 0;
        wait_valid(cyc);
        run(50);
        reset = 1'b1;
        run(1);
        chk("midreset_count", 64'(if_main.count), 64'd0);
        chk("midreset_ovf",   64'(if_small.ovf),  64'd0);
        reset = 1'b0;
        wait_valid(cyc);
        chk("reset_release_latency", 64'(cyc), 64'd100);

        // Enable low holds results and suppresses VALID
        saved = m_count[0];
        en = 1'b0; nv = 0;
        for (int i = 0; i < 300; i++) begin
            run(1);
            if (if_main.valid === 1'b1) nv++;
        end
        chk("en_low_valids", 64'(nv), 64'd0);
        chk("en_low_hold",   64'(if_main.count), 64'(saved));
        en = 1'b1;
        wait_valid(cyc);
        chk("en_rise_latency", 64'(cyc), 64'd100);

        // Randomized input with random enable drops and resets
        rnd = 1;
        for (int blk = 0; blk < 24; blk++) begin
            en    = ($urandom_range(0, 5) != 0);
            reset = ($urandom_range(0, 9) == 0);
            run(1);
            reset = 1'b0;
            run($urandom_range(40, 250));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
